// File: rtl/fetch_unit.sv
// fetch_unit: XM23 instruction fetch stage.
// Owns the program counter, issues in-order 16-bit reads over a req/gnt +
// rvalid handshake, buffers returned words in a small queue and presents the
// queue head to decode. Redirects flush the queue and discard every response
// still owed by memory for the old instruction stream.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned QDEPTH    = 2,
  parameter logic [15:0] NOP_INSTR = 16'h4C00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  stall_in,
  input  logic        redirect_in,
  input  logic [15:0] redirect_pc,
  output logic        imem_req_o,
  output logic [15:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [15:0] imem_rdata_i,
  output logic [15:0] fetch_o,
  output logic [15:0] fetch_pc_o,
  output logic        fetch_valid_o,
  output logic        protocol_err_o
);

  // Counter width holds 0..QDEPTH; credit sum needs one extra bit.
  localparam int unsigned CW = $clog2(QDEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } entry_t;

  logic [15:0]   req_pc_q,   req_pc_d;
  logic [15:0]   resp_pc_q,  resp_pc_d;
  logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] occ_q,      occ_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q,  discard_d;
  logic          err_q,      err_d;
  entry_t        queue_q [QDEPTH];
  entry_t        queue_d [QDEPTH];

  logic          pop_c;
  logic          grant_c;
  logic          ret_c;
  logic          drop_c;
  logic          push_c;
  logic          stray_c;
  logic [SW-1:0] credit_c;
  logic [15:0]   redirect_pc_c;

  // Circular pointer advance with explicit wrap for non-power-of-two depths.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(QDEPTH - 1)) begin
      return '0;
    end
    return p + PW'(1);
  endfunction

  // Queue head presentation; empty queue shows a NOP at address zero.
  assign fetch_valid_o  = (occ_q != '0);
  assign fetch_o        = fetch_valid_o ? queue_q[rd_ptr_q].instr : NOP_INSTR;
  assign fetch_pc_o     = fetch_valid_o ? queue_q[rd_ptr_q].pc    : 16'h0000;
  assign protocol_err_o = err_q;
  assign imem_addr_o    = req_pc_q;

  // Handshake decode: pop, grant, return classification and request credit.
  always_comb begin
    pop_c         = fetch_valid_o & ~(|stall_in) & ~redirect_in;
    credit_c      = SW'(occ_q) + SW'(inflight_q) - SW'(pop_c);
    imem_req_o    = ~rst & ~redirect_in & (credit_c < SW'(QDEPTH));
    grant_c       = imem_req_o & imem_gnt_i;
    ret_c         = imem_rvalid_i & (inflight_q != '0);
    stray_c       = imem_rvalid_i & (inflight_q == '0);
    drop_c        = ret_c & (discard_q != '0);
    push_c        = ret_c & ~drop_c & ~redirect_in;
    redirect_pc_c = redirect_pc & 16'hFFFE;
  end

  // Next-state: PCs, queue contents/pointers, counters and sticky error.
  always_comb begin
    req_pc_d   = req_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;
    discard_d  = discard_q;
    err_d      = err_q;
    for (int i = 0; i < int'(QDEPTH); i++) begin
      queue_d[i] = queue_q[i];
    end

    if (grant_c) begin
      req_pc_d = req_pc_q + 16'd2;
    end

    inflight_d = inflight_q + CW'(grant_c) - CW'(ret_c);

    if (drop_c) begin
      discard_d = discard_q - CW'(1);
    end

    if (push_c) begin
      queue_d[wr_ptr_q] = '{instr: imem_rdata_i, pc: resp_pc_q};
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      resp_pc_d         = resp_pc_q + 16'd2;
    end

    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    occ_d = occ_q + CW'(push_c) - CW'(pop_c);

    if (stray_c) begin
      err_d = 1'b1;
    end

    // Redirect: empty the queue and drop everything still owed by memory.
    if (redirect_in) begin
      occ_d     = '0;
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      req_pc_d  = redirect_pc_c;
      resp_pc_d = redirect_pc_c;
      discard_d = inflight_d;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_pc_q   <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      occ_q      <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      req_pc_q   <= req_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
      err_q      <= err_d;
    end
  end

  // Queue storage; contents are only visible through occupancy, so no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(QDEPTH); i++) begin
      queue_q[i] <= queue_d[i];
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: free-run, stall, redirects, latency-3
// double redirect, wrap-around start PC and stray-response error.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  stall;
  logic        redir;
  logic [15:0] rpc;
  logic        gnt;
  logic [1:0]  lat_sel;
  logic        inj;
  logic [15:0] injd;

  logic        a_req, a_rvalid, a_valid, a_err;
  logic [15:0] a_addr, a_rdata, a_fetch, a_pc;
  logic        b_req, b_rvalid, b_valid, b_err;
  logic [15:0] b_addr, b_rdata, b_fetch, b_pc;

  logic [3:0]  a_pv, b_pv;
  logic [15:0] a_pa [4];
  logic [15:0] b_pa [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall_in(stall), .redirect_in(redir), .redirect_pc(rpc),
    .imem_req_o(a_req), .imem_addr_o(a_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(a_rvalid), .imem_rdata_i(a_rdata),
    .fetch_o(a_fetch), .fetch_pc_o(a_pc), .fetch_valid_o(a_valid), .protocol_err_o(a_err)
  );

  fetch_unit #(.RESET_PC(16'hFFFC)) dut_b (
    .clk(clk), .rst(rst), .stall_in(8'h00), .redirect_in(1'b0), .redirect_pc(16'h0000),
    .imem_req_o(b_req), .imem_addr_o(b_addr), .imem_gnt_i(1'b1),
    .imem_rvalid_i(b_rvalid), .imem_rdata_i(b_rdata),
    .fetch_o(b_fetch), .fetch_pc_o(b_pc), .fetch_valid_o(b_valid), .protocol_err_o(b_err)
  );

  // Memory models: word == address, fixed latency via a grant shift register.
  always @(posedge clk) begin
    if (rst) begin
      a_pv <= '0;
      b_pv <= '0;
    end else begin
      a_pv <= {a_pv[2:0], a_req & gnt};
      b_pv <= {b_pv[2:0], b_req};
    end
    a_pa[0] <= a_addr;
    b_pa[0] <= b_addr;
    for (int i = 1; i < 4; i++) begin
      a_pa[i] <= a_pa[i-1];
      b_pa[i] <= b_pa[i-1];
    end
  end

  assign a_rvalid = a_pv[lat_sel] | inj;
  assign a_rdata  = inj ? injd : a_pa[lat_sel];
  assign b_rvalid = b_pv[0];
  assign b_rdata  = b_pa[0];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 8'h00; redir = 1'b0; rpc = 16'h0000;
    gnt = 1'b1; lat_sel = 2'd0; inj = 1'b0; injd = 16'h0000;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_req",   16'(a_req),   16'h0000);
    chk("rst_addr",  a_addr,       16'h0000);
    chk("rst_fetch", a_fetch,      16'h4C00);
    chk("rst_pc",    a_pc,         16'h0000);
    chk("rst_valid", 16'(a_valid), 16'h0000);
    chk("rst_err",   16'(a_err),   16'h0000);
    chk("rst_b_addr", b_addr,      16'hFFFC);

    // Free run: first request in C0, first valid in C2, then 1/cycle
    cyc(); rst = 1'b0; #1;
    chk("c0_req",  16'(a_req), 16'h0001);
    chk("c0_addr", a_addr,     16'h0000);
    cyc(); #1;
    chk("c1_valid", 16'(a_valid), 16'h0000);
    chk("c1_addr",  a_addr,       16'h0002);
    chk("c1_b_valid", 16'(b_valid), 16'h0000);
    for (int k = 2; k <= 7; k++) begin
      cyc(); #1;
      chk("run_valid", 16'(a_valid), 16'h0001);
      chk("run_fetch", a_fetch, 16'(2 * (k - 2)));
      chk("run_pc",    a_pc,    16'(2 * (k - 2)));
      if (k <= 5) begin
        chk("wrap_pc",    b_pc,    16'(32'hFFFC + 2 * (k - 2)));
        chk("wrap_fetch", b_fetch, 16'(32'hFFFC + 2 * (k - 2)));
      end
    end

    // Stall C8..C11: head held, credits exhausted
    for (int k = 8; k <= 11; k++) begin
      cyc(); stall = 8'h01; #1;
      chk("stall_fetch", a_fetch,     16'h000C);
      chk("stall_pc",    a_pc,        16'h000C);
      chk("stall_req",   16'(a_req),  16'h0000);
    end
    cyc(); stall = 8'h00; #1;
    chk("rel_fetch", a_fetch,    16'h000C);
    chk("rel_req",   16'(a_req), 16'h0001);
    chk("rel_addr",  a_addr,     16'h0010);
    cyc(); #1; chk("rel_fetch1", a_fetch, 16'h000E);
    cyc(); #1; chk("rel_fetch2", a_fetch, 16'h0010);
    cyc(); #1; chk("rel_fetch3", a_fetch, 16'h0012);

    // Redirect to 0101 in C16 with one request in flight
    cyc(); redir = 1'b1; rpc = 16'h0101; #1;
    chk("redir_req",  16'(a_req), 16'h0000);
    chk("redir_head", a_fetch,    16'h0014);
    cyc(); redir = 1'b0; #1;
    chk("redir1_valid", 16'(a_valid), 16'h0000);
    chk("redir1_fetch", a_fetch,      16'h4C00);
    chk("redir1_pc",    a_pc,         16'h0000);
    chk("redir1_req",   16'(a_req),   16'h0001);
    chk("redir1_addr",  a_addr,       16'h0100);
    cyc(); #1;
    chk("redir2_valid", 16'(a_valid), 16'h0000);
    chk("redir2_addr",  a_addr,       16'h0102);
    cyc(); #1;
    chk("redir3_fetch", a_fetch, 16'h0100);
    chk("redir3_pc",    a_pc,    16'h0100);
    cyc(); #1;
    chk("redir4_fetch", a_fetch, 16'h0102);

    // Mid-operation reset, then latency 3 with back-to-back redirects
    cyc(); rst = 1'b1; lat_sel = 2'd2; #1;
    cyc(); #1;
    chk("mrst_valid", 16'(a_valid), 16'h0000);
    chk("mrst_fetch", a_fetch,      16'h4C00);
    chk("mrst_addr",  a_addr,       16'h0000);
    cyc(); rst = 1'b0; #1;
    chk("d0_addr", a_addr, 16'h0000);
    cyc(); #1;
    chk("d1_req",  16'(a_req), 16'h0001);
    chk("d1_addr", a_addr,     16'h0002);
    cyc(); redir = 1'b1; rpc = 16'h0200; #1;
    chk("d2_req", 16'(a_req), 16'h0000);
    cyc(); rpc = 16'h0300; #1;
    chk("d3_req",   16'(a_req),   16'h0000);
    chk("d3_valid", 16'(a_valid), 16'h0000);
    cyc(); redir = 1'b0; #1;
    chk("d4_req",   16'(a_req),   16'h0001);
    chk("d4_addr",  a_addr,       16'h0300);
    chk("d4_valid", 16'(a_valid), 16'h0000);
    cyc(); #1;
    chk("d5_addr",  a_addr,       16'h0302);
    chk("d5_valid", 16'(a_valid), 16'h0000);
    cyc(); #1;
    chk("d6_req",   16'(a_req),   16'h0000);
    chk("d6_valid", 16'(a_valid), 16'h0000);
    cyc(); #1;
    chk("d7_valid", 16'(a_valid), 16'h0000);
    cyc(); #1;
    chk("d8_fetch", a_fetch, 16'h0300);
    chk("d8_pc",    a_pc,    16'h0300);
    cyc(); #1;
    chk("d9_fetch", a_fetch, 16'h0302);
    cyc(); #1;
    chk("d10_valid", 16'(a_valid), 16'h0000);
    cyc(); #1;
    chk("d11_valid", 16'(a_valid), 16'h0000);
    cyc(); #1;
    chk("d12_fetch", a_fetch, 16'h0304);

    // Stray rvalid with nothing outstanding while the queue is full
    cyc(); rst = 1'b1; lat_sel = 2'd0; stall = 8'h80; #1;
    cyc(); #1;
    cyc(); rst = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    chk("e2_req", 16'(a_req), 16'h0000);
    cyc(); inj = 1'b1; injd = 16'hBEEF; #1;
    chk("e3_fetch", a_fetch,    16'h0000);
    chk("e3_err",   16'(a_err), 16'h0000);
    cyc(); inj = 1'b0; stall = 8'h00; #1;
    chk("e4_err",   16'(a_err),   16'h0001);
    chk("e4_fetch", a_fetch,      16'h0000);
    chk("e4_valid", 16'(a_valid), 16'h0001);
    chk("e4_addr",  a_addr,       16'h0004);
    cyc(); #1;
    chk("e5_fetch", a_fetch,    16'h0002);
    chk("e5_err",   16'(a_err), 16'h0001);
    cyc(); #1;
    chk("e6_fetch", a_fetch,    16'h0004);
    chk("e6_err",   16'(a_err), 16'h0001);
    chk("b_err",    16'(b_err), 16'h0000);
    cyc(); rst = 1'b1; #1;
    cyc(); #1;
    chk("err_cleared", 16'(a_err), 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
